// File: rtl/rf_alu_sequencer.sv
// Multi-cycle controller: accepts one ALU instruction, sequences it through
// RegFile/ALU (IDLE->DECODE->EXEC->WB), pulses write-back and latches PSR.
module rf_alu_sequencer #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [REGBITS-1:0] rf_dest_addr,
  output logic [REGBITS-1:0] rf_src_addr,
  output logic               rf_write,
  output logic [WIDTH-1:0]   rf_wr_data,
  input  logic [WIDTH-1:0]   rf_rd_data1,
  input  logic [WIDTH-1:0]   rf_rd_data2,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic [4:0]         alu_flags,
  output logic [4:0]         psr,
  output logic               done,
  output logic               illegal
);

  typedef enum logic [1:0] {
    IDLE, DECODE, EXEC, WB
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;

  state_t             state_q;
  logic [3:0]         opc_q;
  logic [7:0]         imm_q;
  logic [REGBITS-1:0] dest_q, src_q;
  logic [WIDTH-1:0]   alu_a_q, alu_b_q;
  logic [WIDTH-1:0]   wr_data_q;
  logic [2:0]         alu_op_q;
  logic [4:0]         psr_q;
  logic               setf_q, cmp_q;
  logic               rf_write_q, done_q, illegal_q;

  logic [3:0]       sel_d;
  logic             itype_d;
  logic             legal_d, setf_d, cmp_d, zext_d;
  logic [2:0]       op_d;
  logic [WIDTH-1:0] imm_d, opb_d;

  // R-type picks the op from opExt, I-type from the opcode itself.
  always_comb begin
    itype_d = |opc_q;
    sel_d   = itype_d ? opc_q : imm_q[7:4];
    legal_d = 1'b1;
    setf_d  = 1'b0;
    cmp_d   = 1'b0;
    zext_d  = 1'b0;
    op_d    = OP_ADD;
    case (sel_d)
      4'b0101: begin op_d = OP_ADD; setf_d = 1'b1; end
      4'b1001: begin op_d = OP_SUB; setf_d = 1'b1; end
      4'b1011: begin
        op_d   = OP_SUB;
        setf_d = 1'b1;
        cmp_d  = 1'b1;
      end
      4'b0001: begin op_d = OP_AND; zext_d = 1'b1; end
      4'b0010: begin op_d = OP_OR;  zext_d = 1'b1; end
      4'b0011: begin op_d = OP_XOR; zext_d = 1'b1; end
      4'b1101: op_d = OP_MOV;
      default: legal_d = 1'b0;
    endcase
    imm_d = zext_d ? {{(WIDTH-8){1'b0}}, imm_q}
                   : {{(WIDTH-8){imm_q[7]}}, imm_q};
    opb_d = itype_d ? imm_d : rf_rd_data2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opc_q      <= '0;
      imm_q      <= '0;
      dest_q     <= '0;
      src_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      wr_data_q  <= '0;
      psr_q      <= '0;
      setf_q     <= 1'b0;
      cmp_q      <= 1'b0;
      rf_write_q <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      rf_write_q <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            opc_q   <= instr[15:12];
            imm_q   <= instr[7:0];
            dest_q  <= instr[8 +: REGBITS];
            src_q   <= instr[0 +: REGBITS];
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (!legal_d) begin
            illegal_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            alu_a_q  <= rf_rd_data1;
            alu_b_q  <= opb_d;
            alu_op_q <= op_d;
            setf_q   <= setf_d;
            cmp_q    <= cmp_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          wr_data_q <= alu_result;
          done_q    <= 1'b1;
          if (setf_q) psr_q <= alu_flags;
          if (cmp_q) begin
            state_q <= IDLE;
          end else begin
            rf_write_q <= 1'b1;
            state_q    <= WB;
          end
        end
        WB:      state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready  = (state_q == IDLE);
  assign rf_dest_addr = dest_q;
  assign rf_src_addr  = src_q;
  assign rf_write     = rf_write_q;
  assign rf_wr_data   = wr_data_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign psr          = psr_q;
  assign done         = done_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Scoreboard bench for rf_alu_sequencer with RegFile/ALU stand-ins and an
// instruction-level reference model.
module tb_rf_alu_sequencer;

  logic        clk, rst_n;
  logic [15:0] instr;
  logic        instr_valid, instr_ready;
  logic [3:0]  rf_dest_addr, rf_src_addr;
  logic        rf_write;
  logic [15:0] rf_wr_data, rf_rd_data1, rf_rd_data2;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic [4:0]  alu_flags, psr;
  logic        done, illegal;

  rf_alu_sequencer #(.WIDTH(16), .REGBITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .rf_dest_addr(rf_dest_addr), .rf_src_addr(rf_src_addr),
    .rf_write(rf_write), .rf_wr_data(rf_wr_data),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .psr(psr), .done(done), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {result, C, L, F, Z, N}
  function automatic logic [20:0] alu_fn(input logic [2:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, f;
    s = '0; c = 1'b0; f = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0]; c = s[16];
        f = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'd1: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[15:0]; c = s[16];
        f = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = b;
      default: r = '0;
    endcase
    return {r, c, (a < b), f, (r == 16'h0), r[15]};
  endfunction

  always_comb {alu_result, alu_flags} = alu_fn(alu_op, alu_a, alu_b);

  logic [15:0] rf [16];
  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [15:0] pre_data;
  always @(posedge clk) begin
    if (rf_write) rf[rf_dest_addr] <= rf_wr_data;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end
  assign rf_rd_data1 = (rf_dest_addr == 4'd0) ? 16'h0 : rf[rf_dest_addr];
  assign rf_rd_data2 = (rf_src_addr == 4'd0) ? 16'h0 : rf[rf_src_addr];

  typedef struct {
    int          kind;
    logic [3:0]  dest;
    logic [15:0] data;
    logic [4:0]  psr;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_rf [16];
  logic [4:0]  ref_psr;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          fffe_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Architectural model: one instruction at a time on ref_rf/ref_psr.
  task automatic issue_ref(input logic [15:0] ins, input int acc);
    logic [3:0]  opc, key, d, s;
    logic [2:0]  op;
    bit          legal, setf, cmp, zext;
    logic [15:0] a, b, r;
    logic [20:0] alu;
    exp_t        e;
    opc = ins[15:12]; d = ins[11:8]; s = ins[3:0];
    key = (opc == 4'h0) ? ins[7:4] : opc;
    legal = 1; setf = 0; cmp = 0; zext = 0; op = 3'd0;
    case (key)
      4'h5: begin op = 3'd0; setf = 1; end
      4'h9: begin op = 3'd1; setf = 1; end
      4'hB: begin op = 3'd1; setf = 1; cmp = 1; end
      4'h1: begin op = 3'd2; zext = 1; end
      4'h2: begin op = 3'd3; zext = 1; end
      4'h3: begin op = 3'd4; zext = 1; end
      4'hD: op = 3'd5;
      default: legal = 0;
    endcase
    a = ref_rf[d];
    if (opc == 4'h0) b = ref_rf[s];
    else if (zext) b = {8'h00, ins[7:0]};
    else b = {{8{ins[7]}}, ins[7:0]};
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: r = b;
    endcase
    alu = alu_fn(op, a, b);
    if (legal && setf) ref_psr = alu[4:0];
    e.kind = !legal ? 2 : (cmp ? 1 : 0);
    e.due  = !legal ? acc + 1 : acc + 2;
    e.dest = d;
    e.data = r;
    e.psr  = ref_psr;
    if (legal && !cmp && d != 4'h0) ref_rf[d] = r;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (alu_b == 16'hFFFE) fffe_cnt++;
    if (rst_n && (rf_write || done || illegal)) begin
      if (sb.size() == 0) begin
        chk("unexpected_retire", {29'h0, rf_write, done, illegal}, 32'h0);
      end else begin
        e = sb.pop_front();
        k = illegal ? 2 : (rf_write ? 0 : 1);
        chk("kind", k, e.kind);
        chk("latency", cyc, e.due);
        chk("psr", {27'h0, psr}, {27'h0, e.psr});
        if (e.kind == 0) begin
          chk("wb_dest", {28'h0, rf_dest_addr}, {28'h0, e.dest});
          chk("wb_data", {16'h0, rf_wr_data}, {16'h0, e.data});
          chk("wb_done", {31'h0, done}, 32'h1);
        end
        if (e.kind == 2) chk("illegal_quiet", {30'h0, rf_write, done}, 32'h0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] ins, input bit hold);
    bit ok;
    ok = 0;
    instr = ins;
    instr_valid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (instr_ready) begin
        issue_ref(ins, cyc + 1);
        @(posedge clk);
        @(negedge clk);
        ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) chk("accept_timeout", 32'h0, 32'h1);
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 30 && sb.size() != 0; t++) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [15:0] v);
    ref_rf[a] = (a == 4'h0) ? 16'h0 : v;
    pre_addr = a;
    pre_data = v;
    pre_we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  logic [3:0] good_c [7];
  logic [3:0] bad_c [8];

  initial begin
    logic [15:0] ins;
    logic [3:0]  c;
    int          f0;
    good_c = '{4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};
    bad_c  = '{4'h4, 4'h6, 4'h7, 4'h8, 4'hA, 4'hC, 4'hE, 4'hF};
    for (int i = 0; i < 16; i++) ref_rf[i] = 16'h0;
    ref_psr = '0;
    instr = '0; instr_valid = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_ready", {31'h0, instr_ready}, 32'h1);
    chk("rst_outs", {29'h0, rf_write, done, illegal}, 32'h0);
    chk("rst_psr", {27'h0, psr}, 32'h0);
    chk("rst_wdata", {16'h0, rf_wr_data}, 32'h0);
    chk("rst_ops", {alu_a, alu_b}, 32'h0);
    chk("rst_addr", {24'h0, rf_dest_addr, rf_src_addr}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 1; i < 16; i++) set_reg(4'(i), 16'($urandom));
    set_reg(4'd0, 16'h0);

    set_reg(4'd1, 16'd5); set_reg(4'd2, 16'd7);
    send(16'h0152, 0); drain();
    chk("add_r1", {16'h0, rf[1]}, 32'd12);

    set_reg(4'd3, 16'd4);
    f0 = fffe_cnt;
    send(16'h53FE, 0); drain();
    chk("addi_imm_seen", {31'h0, fffe_cnt > f0}, 32'h1);
    chk("addi_r3", {16'h0, rf[3]}, 32'd2);

    set_reg(4'd4, 16'd9); set_reg(4'd5, 16'd9);
    send(16'h04B5, 0); drain();
    chk("cmp_z", {31'h0, psr[1]}, 32'h1);

    send(16'hF000, 0); drain();

    send(16'h06D1, 1); send(16'h0656, 1);
    instr_valid = 1'b0;
    drain();
    chk("b2b_r6", {16'h0, rf[6]}, 32'd24);

    for (int n = 0; n < 200; n++) begin
      c = good_c[$urandom_range(0, 6)];
      case ($urandom_range(0, 9))
        0: ins = {bad_c[$urandom_range(0, 7)], 12'($urandom)};
        1: ins = {4'h0, 4'($urandom), bad_c[$urandom_range(0, 7)],
                  4'($urandom)};
        2, 3, 4, 5: ins = {4'h0, 4'($urandom), c, 4'($urandom)};
        default: ins = {c, 4'($urandom), 8'($urandom)};
      endcase
      send(ins, bit'($urandom_range(0, 1)));
      if (!instr_valid)
        repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    instr_valid = 1'b0;
    drain();

    set_reg(4'd1, 16'd3);
    send(16'h0051, 0);
    for (int t = 0; t < 10 && !rf_write; t++) begin
      @(posedge clk); #1;
    end
    chk("wb_reached", {31'h0, rf_write}, 32'h1);
    chk("psr_before_rst", {31'h0, psr != 5'h0}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_write", {31'h0, rf_write}, 32'h0);
    chk("async_rst_psr", {27'h0, psr}, 32'h0);
    chk("async_rst_ready", {31'h0, instr_ready}, 32'h1);
    sb.delete();
    ref_psr = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("post_rst_ready", {31'h0, instr_ready}, 32'h1);
    @(negedge clk);
    send(16'h0952, 0); drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_alu_sequencer.md
Name: rf_alu_sequencer

Overview:
- Multi-cycle controller that sequences one ALU instruction at a time through the 16-entry register file and ALU.
- Accepts a 16-bit instruction over a valid/ready handshake and decodes it into register-file addresses, ALU control and an immediate.
- Drives a single write-back pulse, then returns to idle.
- Sits between the instruction source (fetch unit or testbench) and the RegFile/ALU datapath; holds the PSR flag register.

Parameters:
- WIDTH, 16, datapath width in bits.
- REGBITS, 4, register address width (16 registers).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr  input  16  instruction word: [15:12] opcode, [11:8] Rdest, [7:4] opExt/imm_hi, [3:0] Rsrc/imm_lo.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  sequencer can accept an instruction.
- rf_dest_addr  output  REGBITS  RegFile destAddr, and port-1 read address.
- rf_src_addr  output  REGBITS  RegFile sourceAddr.
- rf_write  output  1  RegFile regWrite.
- rf_wr_data  output  WIDTH  RegFile wrData.
- rf_rd_data1  input  WIDTH  RegFile readData1 (Rdest value).
- rf_rd_data2  input  WIDTH  RegFile readData2 (Rsrc value).
- alu_a  output  WIDTH  ALU operand A (Rdest value).
- alu_b  output  WIDTH  ALU operand B (Rsrc value or sign-extended immediate).
- alu_op  output  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV(pass B).
- alu_result  input  WIDTH  ALU result.
- alu_flags  input  5  {C,L,F,Z,N} from the ALU.
- psr  output  5  latched flags.
- done  output  1  one-cycle pulse when an instruction retires.
- illegal  output  1  one-cycle pulse when an instruction decodes as unsupported.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rf_write, done, illegal=0.
  - psr=0; rf_wr_data=0; all address and operand registers=0.
  - Takes effect immediately, including mid-instruction; no pending write completes.
- Decode. R-type when opcode=0000; opExt selects the operation:
  - 0101 ADD, 1001 SUB, 1011 CMP (SUB, no write), 0001 AND, 0010 OR, 0011 XOR, 1101 MOV.
- Decode. I-type when opcode is one of the codes above (for example 0101 ADDI):
  - alu_b = sign-extended instr[7:0].
  - I-type AND/OR/XOR zero-extend instead.
- Any other encoding is illegal: pulse illegal in DECODE, no write, psr unchanged, return to IDLE.
- FSM states (all transitions on posedge clk):
  - IDLE: instr_ready=1. If instr_valid, latch instr, drive rf_dest_addr/rf_src_addr from the fields, then go to DECODE.
  - DECODE: register rf_rd_data1→alu_a, and rf_rd_data2 or the immediate→alu_b; set alu_op. Next state is EXEC, or IDLE if illegal.
  - EXEC: capture alu_result into rf_wr_data.
    - ADD/SUB/CMP load psr from alu_flags.
    - Logic ops and MOV leave psr unchanged.
    - Next state is WB, or IDLE with a done pulse for CMP.
  - WB: rf_write=1 for exactly this cycle, with rf_dest_addr and rf_wr_data stable. Pulse done, then go to IDLE.
- Latency: instr accepted at edge 0; rf_write is high during cycle 3; done is high in the same cycle. Throughput is one instruction per 4 cycles (3 for CMP).
- instr_ready is low outside IDLE. instr_valid is ignored while not ready; the instruction is not buffered.
- Write to r0: rf_write is still issued; the RegFile reads r0 as zero.
- Back-to-back dependent instructions are correct without forwarding, because the WB write completes before the next DECODE read.
- rf_dest_addr and rf_src_addr hold their latched value from acceptance until the next acceptance.

Test Plan:
- Reset mid-op: assert rst_n=0 during WB → rf_write drops asynchronously, state=IDLE, psr=0, instr_ready=1 on release.
- ADD: r1=5, r2=7, instr=0x0152 → rf_write pulses once, rf_dest_addr=1, rf_wr_data=12, done in the same cycle, psr Z=0.
- ADDI negative: r3=4, instr=0x53FE (ADDI r3,-2) → rf_wr_data=2, and an immediate of 0xFFFE is observed on alu_b.
- CMP: r4=9, r5=9, instr=0x04B5 → no rf_write, psr Z=1, done after 3 cycles.
- Illegal: instr=0xF000 → illegal pulses once, no rf_write, psr unchanged, instr_ready back high 2 cycles after acceptance.
- Handshake and back-to-back: hold instr_valid high with MOV r6,r1 followed by ADD r6,r6 → second instruction accepted only on its IDLE cycle, r6=2×r1.
